pong_game_ctrl: RTL and testbench



---
 rtl/pong_pkg.sv | 24 ++
 rtl/pong_game_ctrl_frame_countdown.sv | 30 +++
 rtl/pong_game_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared constants for the pong game-flow controller: state codes and counter widths.
package pong_pkg;

  localparam int SCORE_W = 4;
  localparam int FRAME_W = 8;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_ATTRACT = 3'd0;
  localparam logic [2:0] ST_SERVE   = 3'd1;
  localparam logic [2:0] ST_PLAY    = 3'd2;
  localparam logic [2:0] ST_POINT   = 3'd3;
  localparam logic [2:0] ST_OVER    = 3'd4;

  // A zero frame count would never expire, so it is promoted to one frame.
  function automatic logic [FRAME_W-1:0] frames_min1(input int n);
    if (n <= 0) begin
      frames_min1 = FRAME_W'(1);
    end else begin
      frames_min1 = FRAME_W'(n);
    end
  endfunction

endpackage

// File: rtl/pong_game_ctrl_frame_countdown.sv
// Frame countdown: loaded on state entry, decremented on frame ticks, done on the last tick.
module frame_countdown
  import pong_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [FRAME_W-1:0] load_val,
  input  logic               tick,
  output logic               done
);

  logic [FRAME_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - FRAME_W'(1);
    end else begin
      count <= count;
    end
  end

  // A count of zero parks the counter, so states without a timeout never see done.
  assign done = tick && (count == FRAME_W'(1));

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow sequencer: attract/serve/play/point/over on vsync frame ticks, with scores.
// Optional build macro PONG_AUTO_RESTART_EN: OVER times out back to ATTRACT after 4*SERVE_FRAMES.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE        = 9,
  parameter int SERVE_FRAMES     = 60,
  parameter int POINT_FRAMES     = 30,
  parameter int VSYNC_ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vsync,
  input  logic               start,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               ball_run,
  output logic               ball_reset,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               game_over,
  output logic [2:0]         state
);

  localparam logic [FRAME_W-1:0] SERVE_N = frames_min1(SERVE_FRAMES);
  localparam logic [FRAME_W-1:0] POINT_N = frames_min1(POINT_FRAMES);
  localparam logic [SCORE_W-1:0] WIN     = SCORE_W'(WIN_SCORE);
`ifdef PONG_AUTO_RESTART_EN
  localparam logic [FRAME_W-1:0] OVER_N  = frames_min1(4 * ((SERVE_FRAMES < 1) ? 1 : SERVE_FRAMES));
`endif

  logic               vs_q;
  logic               sync1, sync2, sync3;
  logic               vs_act, vs_q_act, tick, start_pe;
  logic               miss_l, miss_r, hit_l, hit_r;
  logic               cd_load, cd_done;
  logic [FRAME_W-1:0] cd_val;
  logic [2:0]         state_nxt;
  logic [SCORE_W-1:0] score1_nxt, score2_nxt;
  logic               serve_dir_nxt;
  logic               enter_serve;

  assign vs_act   = (VSYNC_ACTIVE_LOW != 0) ? ~vsync : vsync;
  assign vs_q_act = (VSYNC_ACTIVE_LOW != 0) ? ~vs_q  : vs_q;
  assign tick     = vs_act & ~vs_q_act;
  assign start_pe = sync2 & ~sync3;

  // A miss arriving in the tick cycle itself still counts for that frame.
  assign hit_l       = miss_l | miss_left;
  assign hit_r       = miss_r | miss_right;
  assign enter_serve = (state_nxt == ST_SERVE) && (state != ST_SERVE);
  assign cd_load     = (state_nxt != state);

  frame_countdown u_countdown (
    .clk      (clk),
    .reset    (reset),
    .load     (cd_load),
    .load_val (cd_val),
    .tick     (tick),
    .done     (cd_done)
  );

  always_comb begin
    case (state_nxt)
      ST_SERVE: cd_val = SERVE_N;
      ST_POINT: cd_val = POINT_N;
`ifdef PONG_AUTO_RESTART_EN
      ST_OVER:  cd_val = OVER_N;
`endif
      default:  cd_val = '0;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    score1_nxt    = score1;
    score2_nxt    = score2;
    serve_dir_nxt = serve_dir;
    case (state)
      ST_ATTRACT: begin
        if (start_pe) begin
          state_nxt  = ST_SERVE;
          score1_nxt = '0;
          score2_nxt = '0;
        end else begin
          state_nxt = ST_ATTRACT;
        end
      end
      ST_SERVE: begin
        if (cd_done) begin
          state_nxt = ST_PLAY;
        end else begin
          state_nxt = ST_SERVE;
        end
      end
      ST_PLAY: begin
        if (tick && hit_l && hit_r) begin
          state_nxt     = ST_POINT;
          serve_dir_nxt = ~serve_dir;
        end else if (tick && hit_l) begin
          state_nxt     = ST_POINT;
          serve_dir_nxt = 1'b0;
          score2_nxt    = (score2 < WIN) ? score2 + 4'd1 : score2;
        end else if (tick && hit_r) begin
          state_nxt     = ST_POINT;
          serve_dir_nxt = 1'b1;
          score1_nxt    = (score1 < WIN) ? score1 + 4'd1 : score1;
        end else begin
          state_nxt = ST_PLAY;
        end
      end
      ST_POINT: begin
        if (cd_done) begin
          state_nxt = ((score1 == WIN) || (score2 == WIN)) ? ST_OVER : ST_SERVE;
        end else begin
          state_nxt = ST_POINT;
        end
      end
      ST_OVER: begin
        if (start_pe) begin
          state_nxt     = ST_SERVE;
          score1_nxt    = '0;
          score2_nxt    = '0;
          serve_dir_nxt = 1'b1;
`ifdef PONG_AUTO_RESTART_EN
        end else if (cd_done) begin
          state_nxt  = ST_ATTRACT;
          score1_nxt = '0;
          score2_nxt = '0;
`endif
        end else begin
          state_nxt = ST_OVER;
        end
      end
      default: begin
        state_nxt = ST_ATTRACT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_q       <= 1'b0;
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync3      <= 1'b0;
      state      <= ST_ATTRACT;
      score1     <= '0;
      score2     <= '0;
      serve_dir  <= 1'b1;
      ball_run   <= 1'b0;
      ball_reset <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      vs_q       <= vsync;
      sync1      <= start;
      sync2      <= sync1;
      sync3      <= sync2;
      state      <= state_nxt;
      score1     <= score1_nxt;
      score2     <= score2_nxt;
      serve_dir  <= serve_dir_nxt;
      ball_run   <= (state_nxt == ST_PLAY);
      ball_reset <= enter_serve;
      game_over  <= (state_nxt == ST_OVER);
    end
  end

  // Sticky miss flags: armed only in PLAY, consumed on each frame tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miss_l <= 1'b0;
      miss_r <= 1'b0;
    end else if (enter_serve || ((state == ST_PLAY) && tick)) begin
      miss_l <= 1'b0;
      miss_r <= 1'b0;
    end else if (state == ST_PLAY) begin
      miss_l <= miss_l | miss_left;
      miss_r <= miss_r | miss_right;
    end else begin
      miss_l <= miss_l;
      miss_r <= miss_r;
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: frame-level game model plus directed and random play.
module tb_pong_game_ctrl;

  localparam int WIN     = 3;
  localparam int SERVE_F = 2;
  localparam int POINT_F = 1;
`ifdef PONG_AUTO_RESTART_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, vsync, start, miss_left, miss_right;
  logic ball_run, ball_reset, serve_dir, game_over;
  logic [3:0] score1, score2;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;
  int frame_cyc = 10;
  bit cmp_en = 1'b0;

  pong_game_ctrl #(
    .WIN_SCORE(WIN), .SERVE_FRAMES(SERVE_F), .POINT_FRAMES(POINT_F), .VSYNC_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .start(start),
    .miss_left(miss_left), .miss_right(miss_right),
    .ball_run(ball_run), .ball_reset(ball_reset), .serve_dir(serve_dir),
    .score1(score1), .score2(score2), .game_over(game_over), .state(state)
  );

  always #5 clk = ~clk;

  // vsync: 4-clock low pulse at the start of every 100-clock frame
  initial begin
    vsync = 1'b1;
    forever begin
      @(negedge clk);
      frame_cyc = (frame_cyc == 99) ? 0 : frame_cyc + 1;
      vsync = (frame_cyc < 4) ? 1'b0 : 1'b1;
    end
  end

  // ---------------- behavioural game model ----------------
  logic [2:0] m_state;
  logic [3:0] m_s1, m_s2;
  logic       m_dir, m_ml, m_mr, m_brst;
  int         m_left;
  logic       prev_vs, sh1, sh2, sh3, tk, spe;
  int         tick_count = 0;

  task automatic go_serve();
    m_state = 3'd1; m_left = SERVE_F; m_ml = 1'b0; m_mr = 1'b0; m_brst = 1'b1;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state = 3'd0; m_s1 = 4'd0; m_s2 = 4'd0; m_dir = 1'b1;
      m_ml = 1'b0; m_mr = 1'b0; m_brst = 1'b0; m_left = 0;
      prev_vs = 1'b0; sh1 = 1'b0; sh2 = 1'b0; sh3 = 1'b0;
    end else begin
      tk = (vsync == 1'b0) && (prev_vs == 1'b1);
      prev_vs = vsync;
      spe = sh2 && !sh3;
      sh3 = sh2; sh2 = sh1; sh1 = start;
      if (tk) tick_count++;
      m_brst = 1'b0;
      case (m_state)
        3'd0: if (spe) begin m_s1 = 4'd0; m_s2 = 4'd0; go_serve(); end
        3'd1: if (tk) begin m_left--; if (m_left == 0) m_state = 3'd2; end
        3'd2: begin
          m_ml = m_ml | miss_left;
          m_mr = m_mr | miss_right;
          if (tk) begin
            if (m_ml && m_mr) m_dir = !m_dir;
            else if (m_ml) begin m_s2 = m_s2 + 4'd1; m_dir = 1'b0; end
            else if (m_mr) begin m_s1 = m_s1 + 4'd1; m_dir = 1'b1; end
            if (m_ml || m_mr) begin m_state = 3'd3; m_left = POINT_F; end
            m_ml = 1'b0; m_mr = 1'b0;
          end
        end
        3'd3: if (tk) begin
          m_left--;
          if (m_left == 0) begin
            if (m_s1 == WIN || m_s2 == WIN) begin m_state = 3'd4; m_left = 4 * SERVE_F; end
            else go_serve();
          end
        end
        3'd4: begin
          if (spe) begin m_s1 = 4'd0; m_s2 = 4'd0; m_dir = 1'b1; go_serve(); end
          else if (AUTO && tk) begin
            m_left--;
            if (m_left == 0) begin m_s1 = 4'd0; m_s2 = 4'd0; m_state = 3'd0; end
          end
        end
        default: m_state = 3'd0;
      endcase
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      n_checks++;
      if (state !== m_state || ball_run !== (m_state == 3'd2) || ball_reset !== m_brst ||
          serve_dir !== m_dir || score1 !== m_s1 || score2 !== m_s2 ||
          game_over !== (m_state == 3'd4)) begin
        n_errors++;
        $display("FAIL model_cmp t=%0t got st=%0d run=%0d brst=%0d dir=%0d s=%0d/%0d go=%0d exp st=%0d brst=%0d dir=%0d s=%0d/%0d",
                 $time, state, ball_run, ball_reset, serve_dir, score1, score2, game_over,
                 m_state, m_brst, m_dir, m_s1, m_s2);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (state == s) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL wait_state: state %0d not reached within %0d cycles (now %0d)", s, budget, state);
    end
  endtask

  task automatic wait_mid();
    for (int i = 0; i < 200 && frame_cyc != 50; i++) @(negedge clk);
    #1;
  endtask

  task automatic pulse_miss(input bit l, input bit r);
    miss_left = l; miss_right = r;
    @(negedge clk); #1;
    miss_left = 1'b0; miss_right = 1'b0;
  endtask

  task automatic press_start();
    start = 1'b1;
    wait_state(3'd1, 20);
    start = 1'b0;
  endtask

  task automatic score_point(input bit l, input bit r);
    wait_state(3'd2, 500);
    wait_mid();
    pulse_miss(l, r);
    wait_state(3'd3, 300);
  endtask

  int t0;

  initial begin
    reset = 1'b1; start = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", state, 0);
    chk("reset_dir", serve_dir, 1);
    reset = 1'b0;
    cmp_en = 1'b1;

    // attract idles without a start press
    repeat (500) @(negedge clk);
    chk("attract_state", state, 0);
    chk("attract_run", ball_run, 0);
    chk("attract_scores", {score1, score2}, 0);

    // start -> SERVE with a ball_reset pulse, PLAY after exactly 2 ticks
    press_start();
    chk("serve_ball_reset", ball_reset, 1);
    t0 = tick_count;
    @(negedge clk);
    chk("serve_ball_reset_one_cycle", ball_reset, 0);
    wait_state(3'd2, 400);
    chk("serve_ticks", tick_count - t0, SERVE_F);
    chk("play_run", ball_run, 1);

    // right miss mid-frame -> point for left player
    wait_mid();
    pulse_miss(1'b0, 1'b1);
    wait_state(3'd3, 300);
    chk("miss_r_score1", score1, 1);
    chk("miss_r_dir", serve_dir, 1);
    t0 = tick_count;
    wait_state(3'd1, 300);
    chk("point_ticks", tick_count - t0, POINT_F);
    chk("reserve_ball_reset", ball_reset, 1);

    // both misses in one frame -> no score, serve_dir toggles
    wait_state(3'd2, 500);
    wait_mid();
    pulse_miss(1'b1, 1'b0);
    repeat (10) @(negedge clk);
    #1;
    pulse_miss(1'b0, 1'b1);
    wait_state(3'd3, 300);
    chk("both_scores", {score1, score2}, 8'h10);
    chk("both_dir", serve_dir, 0);

    // three left misses -> right player wins
    for (int k = 0; k < 3; k++) score_point(1'b1, 1'b0);
    chk("win_score2", score2, 3);
    wait_state(3'd4, 300);
    chk("over_flag", game_over, 1);
    if (AUTO) begin
      t0 = tick_count;
      wait_state(3'd0, 1200);
      chk("auto_restart_ticks", tick_count - t0, 4 * SERVE_F);
      chk("auto_restart_scores", {score1, score2}, 0);
      press_start();
    end else begin
      repeat (2000) @(negedge clk);
      chk("over_persists", state, 4);
      press_start();
      chk("over_start_dir", serve_dir, 1);
    end
    chk("restart_scores", {score1, score2}, 0);

    // asynchronous reset in PLAY with score1=2
    score_point(1'b0, 1'b1);
    score_point(1'b0, 1'b1);
    wait_state(3'd2, 500);
    chk("pre_reset_score1", score1, 2);
    #2 reset = 1'b1;
    #1;
    chk("async_state", state, 0);
    chk("async_scores", {score1, score2}, 0);
    chk("async_flags", {ball_run, ball_reset, game_over, serve_dir}, 4'b0001);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // random play: misses and start presses arrive at random
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk); #1;
      miss_left  = ($urandom_range(0, 149) == 0);
      miss_right = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 149) == 0) start = ~start;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
